cabac_neighbour_ctrl: RTL and testbench
=======================================

// Module: cabac_neighbour_ctrl
// PURPOSE
//  Sequencer between the CABAC syntax encoder and the single-port top-neighbour store (8 bits per LCU column).
//  Per LCU it fetches the top neighbour word, tracks the left neighbour word, collects the updated word, and writes it back.
//  Store reads and writes never overlap.
//  Sits directly upstream of the neighbour RAM. It drives r_en/r_addr/w_en/w_addr/w_data and consumes r_data.
// PARAMETERS
//  DATA_W  8               neighbour word width (top/left ctx info)
//  X_W     `PIC_X_WIDTH    LCU column index width (store address width)
//  Y_W     `PIC_Y_WIDTH    LCU row index width
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  start_i      in   1      1-cycle pulse: begin LCU at lcu_x_i/lcu_y_i
//  lcu_x_i      in   X_W    LCU column, sampled with start_i
//  lcu_y_i      in   Y_W    LCU row, sampled with start_i
//  upd_en_i     in   1      neighbour word update strobe
//  upd_data_i   in   DATA_W updated neighbour word for the current LCU
//  done_i       in   1      1-cycle pulse: LCU finished, commit the word
//  rdy_o        out  1      top/left outputs valid; LCU may be coded
//  top_data_o   out  DATA_W top neighbour word (0 when invalid)
//  top_valid_o  out  1      top neighbour exists (lcu_y != 0)
//  left_data_o  out  DATA_W left neighbour word (0 when invalid)
//  left_valid_o out  1      left neighbour exists (lcu_x != 0)
//  r_en_o       out  1      store read enable
//  r_addr_o     out  X_W    store read address
//  r_data_i     in   DATA_W store read data, valid 1 cycle after r_en_o
//  w_en_o       out  1      store write enable (the store gives write priority)
//  w_addr_o     out  X_W    store write address
//  w_data_o     out  DATA_W store write data
// BEHAVIOUR
//  - Reset values: all outputs are 0. State is IDLE. All internal registers (x_r, y_r, upd_r, left_r, start_pend) are 0.
//  - FSM states: IDLE, RD, CAP, READY, WR.
//  - IDLE + start_i: latch x_r/y_r and clear upd_r.
//      If lcu_y_i != 0, go to RD. Otherwise, go to READY with top_data_o=0 and top_valid_o=0.
//  - RD: r_en_o=1 and r_addr_o=x_r for exactly 1 cycle. Then go to CAP.
//  - CAP: top_data_o<=r_data_i and top_valid_o<=1. Then go to READY.
//  - Latency from start_i to rdy_o: 3 cycles when y!=0, 1 cycle when y==0.
//  - READY: rdy_o=1. An upd_en_i strobe loads upd_r; the last strobe wins.
//      done_i moves the FSM to WR. If upd_en_i and done_i coincide, upd_data_i is the value committed.
//  - WR: w_en_o=1, w_addr_o=x_r, w_data_o=upd_r for 1 cycle. Also left_r<=upd_r. Then go to IDLE.
//      If no update arrived during the LCU, the committed word is 0.
//  - left_valid_o is (x_r != 0), evaluated while in READY. left_data_o = left_valid_o ? left_r : 0.
//      At x==0, left_r is not used; it is overwritten at the end of that LCU.
//  - start_i arriving during WR sets start_pend and latches x/y. The FSM then enters the fetch path directly from WR, with no extra IDLE cycle.
//      This gives back-to-back LCUs with no read/write collision.
//      A one-column picture (same x every LCU) reads the word just written. This is correct because the write completes first.
//  - start_i arriving in RD, CAP or READY is ignored. done_i outside READY is ignored.
//  - r_en_o and w_en_o are never both 1 in the same cycle (invariant).
//  - rst_n asserted mid-operation: return immediately to reset values. A pending write or read is dropped.
// CONFIGURATION
//  CABAC_NEIGHBOUR_CHK_EN defined:
//    Adds port err_o (out, 1). err_o is a sticky flag set by:
//      start_i in RD/CAP/READY;
//      done_i outside READY;
//      upd_en_i outside READY.
//    err_o is cleared only by reset.
//  CABAC_NEIGHBOUR_CHK_EN undefined: no err_o port. The same events are ignored silently.
// STRUCTURE
//  - Shared package/defines (enc_defines.v): PIC_X_WIDTH, PIC_Y_WIDTH, CABAC_NB_DATA_W=8, FSM state localparams (IDLE..WR).
//  - Single module with no sub-module. The neighbour RAM is instantiated by the parent, beside this block.
// TESTING
//  - Reset then start_i at x=3, y=0: rdy_o=1 at +1 cycle, top_valid_o=0, left_valid_o=1, left_data_o=0, no r_en_o pulse.
//  - Preload store[5]=8'hA7, then start at x=5, y=2: r_en_o at +1 with r_addr_o=5; top_data_o=8'hA7, top_valid_o=1, rdy_o=1 at +3.
//  - In READY: upd 8'h11, then upd 8'h3C together with done_i:
//      next cycle w_en_o=1, w_addr_o=x, w_data_o=8'h3C.
//      Next LCU at x+1 shows left_data_o=8'h3C.
//  - start_i in the WR cycle (x=0, one-column picture): write of 8'h5A completes first; read of address 0 follows and returns 8'h5A;
//      r_en_o and w_en_o are never high together.
//  - rst_n pulsed low during RD: all outputs are 0 immediately and no write occurs.
//      With CABAC_NEIGHBOUR_CHK_EN, start_i in READY sets err_o=1, and err_o stays 1 until reset.

Source files
------------

// File: rtl/cabac_neighbour_ctrl_pkg.sv
// Shared widths and FSM encoding for the CABAC top/left neighbour sequencer.
package cabac_neighbour_ctrl_pkg;

  localparam int unsigned PIC_X_WIDTH     = 8;
  localparam int unsigned PIC_Y_WIDTH     = 8;
  localparam int unsigned CABAC_NB_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CAP   = 3'd2,
    ST_READY = 3'd3,
    ST_WR    = 3'd4
  } nb_state_e;

endpackage

// File: rtl/cabac_neighbour_ctrl.sv
// Fetches/commits the per-column top neighbour word and tracks the left word per LCU.
// Optional sticky protocol-error flag err_o when CABAC_NEIGHBOUR_CHK_EN is defined.
module cabac_neighbour_ctrl
  import cabac_neighbour_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = CABAC_NB_DATA_W,
  parameter int unsigned X_W    = PIC_X_WIDTH,
  parameter int unsigned Y_W    = PIC_Y_WIDTH
) (
`ifdef CABAC_NEIGHBOUR_CHK_EN
  output logic              err_o,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [X_W-1:0]    lcu_x_i,
  input  logic [Y_W-1:0]    lcu_y_i,
  input  logic              upd_en_i,
  input  logic [DATA_W-1:0] upd_data_i,
  input  logic              done_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] top_data_o,
  output logic              top_valid_o,
  output logic [DATA_W-1:0] left_data_o,
  output logic              left_valid_o,
  output logic              r_en_o,
  output logic [X_W-1:0]    r_addr_o,
  input  logic [DATA_W-1:0] r_data_i,
  output logic              w_en_o,
  output logic [X_W-1:0]    w_addr_o,
  output logic [DATA_W-1:0] w_data_o
);

  nb_state_e         state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [DATA_W-1:0] upd_q, upd_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] top_data_q, top_data_d;
  logic              top_valid_q, top_valid_d;
  logic [DATA_W-1:0] left_data_q, left_data_d;
  logic              left_valid_q, left_valid_d;
  logic              r_en_q, r_en_d;
  logic [X_W-1:0]    r_addr_q, r_addr_d;
  logic              w_en_q, w_en_d;
  logic [X_W-1:0]    w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              launch;
  logic [DATA_W-1:0] left_src;
`ifdef CABAC_NEIGHBOUR_CHK_EN
  logic              err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      upd_q        <= '0;
      left_q       <= '0;
      rdy_q        <= 1'b0;
      top_data_q   <= '0;
      top_valid_q  <= 1'b0;
      left_data_q  <= '0;
      left_valid_q <= 1'b0;
      r_en_q       <= 1'b0;
      r_addr_q     <= '0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
`ifdef CABAC_NEIGHBOUR_CHK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      upd_q        <= upd_d;
      left_q       <= left_d;
      rdy_q        <= rdy_d;
      top_data_q   <= top_data_d;
      top_valid_q  <= top_valid_d;
      left_data_q  <= left_data_d;
      left_valid_q <= left_valid_d;
      r_en_q       <= r_en_d;
      r_addr_q     <= r_addr_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
`ifdef CABAC_NEIGHBOUR_CHK_EN
      err_q        <= err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    upd_d        = upd_q;
    left_d       = left_q;
    rdy_d        = 1'b0;
    top_data_d   = top_data_q;
    top_valid_d  = top_valid_q;
    left_data_d  = left_data_q;
    left_valid_d = left_valid_q;
    r_en_d       = 1'b0;
    r_addr_d     = '0;
    w_en_d       = 1'b0;
    w_addr_d     = '0;
    w_data_d     = '0;
    launch       = 1'b0;
    // A launch straight out of WR must see the word being committed this cycle.
    left_src     = (state_q == ST_WR) ? upd_q : left_q;

    unique case (state_q)
      ST_IDLE: launch = start_i;
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        state_d      = ST_READY;
        rdy_d        = 1'b1;
        top_data_d   = r_data_i;
        top_valid_d  = 1'b1;
        left_valid_d = (x_q != '0);
        left_data_d  = (x_q != '0) ? left_q : '0;
      end
      ST_READY: begin
        rdy_d = 1'b1;
        if (upd_en_i) upd_d = upd_data_i;
        if (done_i) begin
          state_d  = ST_WR;
          rdy_d    = 1'b0;
          w_en_d   = 1'b1;
          w_addr_d = x_q;
          w_data_d = upd_en_i ? upd_data_i : upd_q;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
        left_d  = upd_q;
        launch  = start_i;
      end
      default: state_d = ST_IDLE;
    endcase

    // New LCU: fetch the top word unless on the first row.
    if (launch) begin
      x_d          = lcu_x_i;
      y_d          = lcu_y_i;
      upd_d        = '0;
      top_data_d   = '0;
      top_valid_d  = 1'b0;
      left_data_d  = '0;
      left_valid_d = 1'b0;
      if (y_d != '0) begin
        state_d  = ST_RD;
        r_en_d   = 1'b1;
        r_addr_d = lcu_x_i;
      end else begin
        state_d      = ST_READY;
        rdy_d        = 1'b1;
        left_valid_d = (lcu_x_i != '0);
        left_data_d  = (lcu_x_i != '0) ? left_src : '0;
      end
    end

`ifdef CABAC_NEIGHBOUR_CHK_EN
    err_d = err_q;
    if (start_i && (state_q == ST_RD || state_q == ST_CAP || state_q == ST_READY)) err_d = 1'b1;
    if ((done_i || upd_en_i) && state_q != ST_READY) err_d = 1'b1;
`endif
  end

  assign rdy_o        = rdy_q;
  assign top_data_o   = top_data_q;
  assign top_valid_o  = top_valid_q;
  assign left_data_o  = left_data_q;
  assign left_valid_o = left_valid_q;
  assign r_en_o       = r_en_q;
  assign r_addr_o     = r_addr_q;
  assign w_en_o       = w_en_q;
  assign w_addr_o     = w_addr_q;
  assign w_data_o     = w_data_q;
`ifdef CABAC_NEIGHBOUR_CHK_EN
  assign err_o        = err_q;
`endif

endmodule

// File: tb/tb_cabac_neighbour_ctrl.sv
// Directed bench for cabac_neighbour_ctrl with a write-priority neighbour RAM model.
// Exercises err_o as well when CABAC_NEIGHBOUR_CHK_EN is defined.
module tb_cabac_neighbour_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, upd_en_i, done_i;
  logic [7:0] lcu_x_i, lcu_y_i, upd_data_i;
  logic       rdy_o, top_valid_o, left_valid_o, r_en_o, w_en_o;
  logic [7:0] top_data_o, left_data_o, r_addr_o, w_addr_o, w_data_o;
  logic [7:0] r_data_i;
`ifdef CABAC_NEIGHBOUR_CHK_EN
  logic       err_o;
`endif

  logic [7:0] mem [256];
  logic       preload;
  int         n_checks = 0;
  int         n_errors = 0;
  int         wr_cnt   = 0;
  int         rd_cnt   = 0;
  int         coll_cnt = 0;
  int         wr_snap;

  always #5 clk = ~clk;

  cabac_neighbour_ctrl dut (
`ifdef CABAC_NEIGHBOUR_CHK_EN
    .err_o       (err_o),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .lcu_x_i     (lcu_x_i),
    .lcu_y_i     (lcu_y_i),
    .upd_en_i    (upd_en_i),
    .upd_data_i  (upd_data_i),
    .done_i      (done_i),
    .rdy_o       (rdy_o),
    .top_data_o  (top_data_o),
    .top_valid_o (top_valid_o),
    .left_data_o (left_data_o),
    .left_valid_o(left_valid_o),
    .r_en_o      (r_en_o),
    .r_addr_o    (r_addr_o),
    .r_data_i    (r_data_i),
    .w_en_o      (w_en_o),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o)
  );

  // Single-port store: write wins over read, read data registered.
  always @(posedge clk) begin
    if (preload) mem[5] <= 8'hA7;
    else if (w_en_o) mem[w_addr_o] <= w_data_o;
    else if (r_en_o) r_data_i <= mem[r_addr_o];
    if (w_en_o) wr_cnt++;
    if (r_en_o) rd_cnt++;
    if (r_en_o && w_en_o) coll_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rdy"}, rdy_o, 0);
    check({tag, " top_data"}, top_data_o, 0);
    check({tag, " top_valid"}, top_valid_o, 0);
    check({tag, " left_data"}, left_data_o, 0);
    check({tag, " left_valid"}, left_valid_o, 0);
    check({tag, " r_en"}, r_en_o, 0);
    check({tag, " r_addr"}, r_addr_o, 0);
    check({tag, " w_en"}, w_en_o, 0);
    check({tag, " w_addr"}, w_addr_o, 0);
    check({tag, " w_data"}, w_data_o, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    r_data_i = 8'h00;
    rst_n = 1'b0; start_i = 1'b0; upd_en_i = 1'b0; done_i = 1'b0;
    lcu_x_i = 8'h0; lcu_y_i = 8'h0; upd_data_i = 8'h0; preload = 1'b1;
    tick();
    preload = 1'b0;
    check_all_zero("reset");
`ifdef CABAC_NEIGHBOUR_CHK_EN
    check("reset err", err_o, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // First-row LCU at x=3: ready after one cycle, no read.
    start_i = 1'b1; lcu_x_i = 8'd3; lcu_y_i = 8'd0;
    tick();
    start_i = 1'b0;
    check("y0 rdy", rdy_o, 1);
    check("y0 top_valid", top_valid_o, 0);
    check("y0 top_data", top_data_o, 0);
    check("y0 left_valid", left_valid_o, 1);
    check("y0 left_data", left_data_o, 0);
    check("y0 no read", rd_cnt, 0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("noupd w_en", w_en_o, 1);
    check("noupd w_addr", w_addr_o, 3);
    check("noupd w_data", w_data_o, 0);
    tick();
    check("noupd w_en off", w_en_o, 0);

    // Row 2, x=5: read at +1, data ready at +3.
    start_i = 1'b1; lcu_x_i = 8'd5; lcu_y_i = 8'd2;
    tick();
    start_i = 1'b0;
    check("rd r_en", r_en_o, 1);
    check("rd r_addr", r_addr_o, 5);
    check("rd rdy", rdy_o, 0);
    tick();
    check("cap r_en", r_en_o, 0);
    check("cap rdy", rdy_o, 0);
    tick();
    check("ready rdy", rdy_o, 1);
    check("ready top_data", top_data_o, 8'hA7);
    check("ready top_valid", top_valid_o, 1);
    check("ready left_valid", left_valid_o, 1);
    check("ready left_data", left_data_o, 0);

    // Last update wins, coinciding with done.
    upd_en_i = 1'b1; upd_data_i = 8'h11;
    tick();
    upd_data_i = 8'h3C; done_i = 1'b1;
    tick();
    upd_en_i = 1'b0; done_i = 1'b0;
    check("commit w_en", w_en_o, 1);
    check("commit w_addr", w_addr_o, 5);
    check("commit w_data", w_data_o, 8'h3C);
    check("commit rdy", rdy_o, 0);
    tick();
    check("commit store", mem[5], 8'h3C);

    // Next column inherits the committed word as left neighbour.
    start_i = 1'b1; lcu_x_i = 8'd6; lcu_y_i = 8'd0;
    tick();
    start_i = 1'b0;
    check("left rdy", rdy_o, 1);
    check("left valid", left_valid_o, 1);
    check("left data", left_data_o, 8'h3C);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();

    // One-column picture: start during WR reads back the word just written.
    start_i = 1'b1; lcu_x_i = 8'd0; lcu_y_i = 8'd0;
    tick();
    start_i = 1'b0;
    check("x0 left_valid", left_valid_o, 0);
    check("x0 left_data", left_data_o, 0);
    upd_en_i = 1'b1; upd_data_i = 8'h5A; done_i = 1'b1;
    tick();
    upd_en_i = 1'b0; done_i = 1'b0;
    check("wr5a w_en", w_en_o, 1);
    check("wr5a w_data", w_data_o, 8'h5A);
    start_i = 1'b1; lcu_x_i = 8'd0; lcu_y_i = 8'd1;
    tick();
    start_i = 1'b0;
    check("b2b r_en", r_en_o, 1);
    check("b2b r_addr", r_addr_o, 0);
    check("b2b w_en", w_en_o, 0);
    tick();
    tick();
    check("b2b rdy", rdy_o, 1);
    check("b2b top_data", top_data_o, 8'h5A);
    check("b2b top_valid", top_valid_o, 1);
    check("b2b left_valid", left_valid_o, 0);
`ifdef CABAC_NEIGHBOUR_CHK_EN
    check("err clean", err_o, 0);
`endif

    // start in READY is ignored.
    start_i = 1'b1; lcu_x_i = 8'd9; lcu_y_i = 8'd0;
    tick();
    start_i = 1'b0;
    check("ign rdy", rdy_o, 1);
    check("ign top_data", top_data_o, 8'h5A);
`ifdef CABAC_NEIGHBOUR_CHK_EN
    check("err set", err_o, 1);
`endif
    upd_en_i = 1'b1; upd_data_i = 8'h77; done_i = 1'b1;
    tick();
    upd_en_i = 1'b0; done_i = 1'b0;
    check("ign w_addr", w_addr_o, 0);
    check("ign w_data", w_data_o, 8'h77);
    tick();
`ifdef CABAC_NEIGHBOUR_CHK_EN
    check("err sticky", err_o, 1);
`endif

    // Reset during RD drops the LCU.
    start_i = 1'b1; lcu_x_i = 8'd2; lcu_y_i = 8'd3;
    tick();
    start_i = 1'b0;
    check("pre-rst r_en", r_en_o, 1);
    wr_snap = wr_cnt;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
`ifdef CABAC_NEIGHBOUR_CHK_EN
    check("midrst err", err_o, 0);
`endif
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst no write", wr_cnt, wr_snap);
    check("midrst idle rdy", rdy_o, 0);
    check("no r/w collision", coll_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
